// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the I/D memory arbiter: FSM states, owner IDs and
// the width of the starvation streak counter.
package mem_arbiter_pkg;
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_WAIT   = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   localparam logic OWN_I    = 1'b0;
   localparam logic OWN_D    = 1'b1;
   localparam int   STREAK_W = 4;
endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant decision: D wins ties unless it has starved fetch for
// STARVE_LIMIT consecutive grants.
module mem_arb_pick
   import mem_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic                i_req,
   input  logic                d_req,
   input  logic [STREAK_W-1:0] d_streak,
   output logic                grant_i,
   output logic                grant_d,
   output logic [STREAK_W-1:0] next_streak
);
   localparam logic [STREAK_W-1:0] LIM = STREAK_W'(STARVE_LIMIT);

   logic w_starved;
   assign w_starved = (d_streak == LIM);

   always_comb begin
      grant_i     = 1'b0;
      grant_d     = 1'b0;
      next_streak = d_streak;
      if (d_req && !(i_req && w_starved)) grant_d = 1'b1;
      else if (i_req)                     grant_i = 1'b1;

      // Streak only counts D grants that actually made fetch wait.
      if (grant_i)                               next_streak = '0;
      else if (grant_d && i_req && !w_starved)   next_streak = d_streak + 1'b1;
   end
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port synchronous RAM between fetch (I) and load/store (D),
// one transaction in flight: IDLE -> ACCESS -> [WAIT] -> DONE -> IDLE.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int RD_LAT       = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_req,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic [DATA_W-1:0]   i_rdata,
   output logic                i_ready,
   output logic                i_stall,
   input  logic                d_req,
   input  logic [DATA_W/8-1:0] d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_ready,
   output logic                d_stall,
   output logic                mem_en,
   output logic [DATA_W/8-1:0] mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                busy
);
   localparam int BE_W = DATA_W / 8;

   state_t              r_state, w_next;
   logic                r_owner;
   logic [ADDR_W-1:0]   r_addr;
   logic [BE_W-1:0]     r_we;
   logic [DATA_W-1:0]   r_wdata;
   logic [2:0]          r_lat_cnt;
   logic [DATA_W-1:0]   r_i_rdata, r_d_rdata;
   logic [STREAK_W-1:0] r_d_streak, w_next_streak;
   logic                w_grant_i, w_grant_d, w_last;

   mem_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
      .i_req       (i_req),
      .d_req       (d_req),
      .d_streak    (r_d_streak),
      .grant_i     (w_grant_i),
      .grant_d     (w_grant_d),
      .next_streak (w_next_streak)
   );

   assign w_last = (r_lat_cnt == 3'd1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (w_grant_i || w_grant_d) w_next = S_ACCESS;
         S_ACCESS: w_next = (r_we == '0) ? S_WAIT : S_DONE;
         S_WAIT:   if (w_last) w_next = S_DONE;
         S_DONE:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // Request fields are sampled only at grant, so requester changes mid-flight are ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_owner    <= OWN_I;
         r_addr     <= '0;
         r_we       <= '0;
         r_wdata    <= '0;
         r_lat_cnt  <= '0;
         r_i_rdata  <= '0;
         r_d_rdata  <= '0;
         r_d_streak <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (w_grant_i || w_grant_d) begin
               r_owner    <= w_grant_d ? OWN_D : OWN_I;
               r_addr     <= w_grant_d ? d_addr : i_addr;
               r_we       <= w_grant_d ? d_we : '0;
               r_wdata    <= w_grant_d ? d_wdata : '0;
               r_d_streak <= w_next_streak;
            end
            S_ACCESS: r_lat_cnt <= 3'(RD_LAT);
            S_WAIT: begin
               r_lat_cnt <= r_lat_cnt - 1'b1;
               if (w_last) begin
                  if (r_owner == OWN_D) r_d_rdata <= mem_rdata;
                  else                  r_i_rdata <= mem_rdata;
               end
            end
            default: ;
         endcase
      end
   end

   assign mem_en    = (r_state == S_ACCESS);
   assign mem_we    = mem_en ? r_we : '0;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign i_ready   = (r_state == S_DONE) && (r_owner == OWN_I);
   assign d_ready   = (r_state == S_DONE) && (r_owner == OWN_D);
   assign i_rdata   = r_i_rdata;
   assign d_rdata   = r_d_rdata;
   assign i_stall   = i_req & ~i_ready;
   assign d_stall   = d_req & ~d_ready;
   assign busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench: two arbiters (RD_LAT=1 and RD_LAT=3) each with a latency-accurate RAM model.
module tb_mem_arbiter;
   typedef struct {
      bit          port;   // 0=I, 1=D
      logic [3:0]  we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] data;
      int          rdy;    // expected ready cycle, -1 = don't care
   } exp_t;

   logic        clk = 1'b0;
   logic        rst[2];
   logic        i_req[2], i_ready[2], i_stall[2];
   logic [31:0] i_addr[2], i_rdata[2];
   logic        d_req[2], d_ready[2], d_stall[2];
   logic [3:0]  d_we[2], mem_we[2];
   logic [31:0] d_addr[2], d_wdata[2], d_rdata[2];
   logic        mem_en[2], busy[2];
   logic [31:0] mem_addr[2], mem_wdata[2], mem_rdata[2];

   logic [31:0] mem[2][256];
   logic [31:0] pipe[2][4];
   int          cyc = 0;
   int          checks = 0, failures = 0;
   int          en_cnt[2];
   exp_t        sb0[$], sb1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_arbiter #(.RD_LAT(1), .STARVE_LIMIT(4)) u_dut0 (
      .clk(clk), .rst(rst[0]),
      .i_req(i_req[0]), .i_addr(i_addr[0]), .i_rdata(i_rdata[0]), .i_ready(i_ready[0]), .i_stall(i_stall[0]),
      .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]), .d_rdata(d_rdata[0]),
      .d_ready(d_ready[0]), .d_stall(d_stall[0]),
      .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
      .mem_rdata(mem_rdata[0]), .busy(busy[0]));

   mem_arbiter #(.RD_LAT(3), .STARVE_LIMIT(4)) u_dut1 (
      .clk(clk), .rst(rst[1]),
      .i_req(i_req[1]), .i_addr(i_addr[1]), .i_rdata(i_rdata[1]), .i_ready(i_ready[1]), .i_stall(i_stall[1]),
      .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]), .d_rdata(d_rdata[1]),
      .d_ready(d_ready[1]), .d_stall(d_stall[1]),
      .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
      .mem_rdata(mem_rdata[1]), .busy(busy[1]));

   function automatic logic [31:0] init_word(input int k, input int a);
      if (k == 0) begin
         case (a)
            'h040: return 32'h2402_0005;
            'h200: return 32'h0D0D_0D0D;
            'h300: return 32'h0101_0101;
            default: return 32'h0;
         endcase
      end else begin
         case (a)
            'h080: return 32'h1122_3344;
            'h090: return 32'h5555_AAAA;
            'h0A0: return 32'h0BAD_F00D;
            'h0C0: return 32'h1234_5678;
            default: return 32'h0;
         endcase
      end
   endfunction

   // RAM model: sampled at the mem_en edge, data emerges RD_LAT cycles later.
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (cyc == 0) begin
            for (int j = 0; j < 256; j++) mem[k][j] <= init_word(k, j * 4);
         end else if (mem_en[k]) begin
            for (int b = 0; b < 4; b++)
               if (mem_we[k][b]) mem[k][mem_addr[k][9:2]][8*b +: 8] <= mem_wdata[k][8*b +: 8];
            pipe[k][0] <= mem[k][mem_addr[k][9:2]];
         end
         for (int j = 1; j < 4; j++) pipe[k][j] <= pipe[k][j-1];
      end
   end
   assign mem_rdata[0] = pipe[0][0];
   assign mem_rdata[1] = pipe[1][2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0d actual=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   task automatic mon(input int k);
      exp_t e;
      bit   have;
      if (rst[k]) begin en_cnt[k] = 0; return; end
      chk("ready_exclusive", 32'(i_ready[k] & d_ready[k]), 0);
      if (!mem_en[k]) chk("mem_we_idle", 32'(mem_we[k]), 0);
      have = (k == 0) ? (sb0.size() > 0) : (sb1.size() > 0);
      if (have) e = (k == 0) ? sb0[0] : sb1[0];
      if (mem_en[k]) begin
         en_cnt[k]++;
         chk("mem_en_expected", 32'(have), 1);
         if (have) begin
            chk("mem_addr", mem_addr[k], e.addr);
            chk("mem_we", 32'(mem_we[k]), 32'(e.we));
            if (e.we != 0) chk("mem_wdata", mem_wdata[k], e.wdata);
            chk("stall_owner", 32'(e.port ? d_stall[k] : i_stall[k]), 1);
         end
      end
      if (i_ready[k] || d_ready[k]) begin
         chk("ready_expected", 32'(have), 1);
         if (have) begin
            if (k == 0) void'(sb0.pop_front()); else void'(sb1.pop_front());
            chk("ready_port", 32'(d_ready[k]), 32'(e.port));
            chk("mem_en_once", en_cnt[k], 1);
            chk("addr_held", mem_addr[k], e.addr);
            chk("stall_on_ready", 32'(e.port ? d_stall[k] : i_stall[k]), 0);
            if (e.we == 0) chk("rdata", e.port ? d_rdata[k] : i_rdata[k], e.data);
            if (e.rdy >= 0) chk("latency", cyc, e.rdy);
         end
         en_cnt[k] = 0;
      end
   endtask

   always @(negedge clk) begin
      mon(0);
      mon(1);
   end

   task automatic push(input int k, input exp_t e);
      if (k == 0) sb0.push_back(e); else sb1.push_back(e);
   endtask

   task automatic do_txn(input int k, input bit port, input logic [3:0] we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp, input int lat);
      exp_t e;
      int   n = 0;
      @(posedge clk); #1;
      e.port = port; e.we = we; e.addr = addr; e.wdata = wdata; e.data = exp; e.rdy = cyc + lat;
      push(k, e);
      if (port) begin
         d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wdata;
      end else begin
         i_req[k] = 1'b1; i_addr[k] = addr;
      end
      do begin @(negedge clk); n++; end
      while (!(port ? d_ready[k] : i_ready[k]) && n < 100);
      if (n >= 100) begin failures++; checks++; $display("FAIL txn_timeout k=%0d addr=%h", k, addr); end
      @(posedge clk); #1;
      if (port) begin d_req[k] = 1'b0; d_we[k] = '0; end
      else i_req[k] = 1'b0;
   endtask

   initial begin
      exp_t e;
      for (int k = 0; k < 2; k++) begin
         rst[k] = 1'b1; i_req[k] = 0; d_req[k] = 0; d_we[k] = '0;
         i_addr[k] = '0; d_addr[k] = '0; d_wdata[k] = '0; en_cnt[k] = 0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk("rst_busy", 32'(busy[k]), 0);
         chk("rst_mem_en", 32'(mem_en[k]), 0);
         chk("rst_mem_we", 32'(mem_we[k]), 0);
         chk("rst_ready", 32'({i_ready[k], d_ready[k]}), 0);
         chk("rst_mem_addr", mem_addr[k], 0);
         chk("rst_rdata", i_rdata[k] | d_rdata[k], 0);
      end
      @(posedge clk); #1;
      rst[0] = 1'b0; rst[1] = 1'b0;

      // Fetch read, then D word write and read-back on the RD_LAT=1 arbiter.
      do_txn(0, 0, 4'h0, 32'h40, 0, 32'h2402_0005, 3);
      do_txn(0, 1, 4'hF, 32'h100, 32'hDEAD_BEEF, 0, 2);
      do_txn(0, 1, 4'h0, 32'h100, 0, 32'hDEAD_BEEF, 3);

      // Contention: D held continuously, expected grant order D,D,D,D,I,D.
      e.we = '0; e.wdata = '0; e.rdy = -1;
      for (int j = 0; j < 6; j++) begin
         e.port = (j != 4);
         e.addr = e.port ? 32'h200 : 32'h300;
         e.data = e.port ? 32'h0D0D_0D0D : 32'h0101_0101;
         push(0, e);
      end
      @(posedge clk); #1;
      i_req[0] = 1; i_addr[0] = 32'h300; d_req[0] = 1; d_addr[0] = 32'h200; d_we[0] = '0;
      fork
         begin
            int n = 0;
            do begin @(negedge clk); n++; end while (!i_ready[0] && n < 200);
            chk("streak_cleared", 32'(u_dut0.r_d_streak), 0);
            @(posedge clk); #1; i_req[0] = 0;
         end
         begin
            int n = 0, got = 0;
            while (got < 5 && n < 200) begin
               @(negedge clk); n++;
               if (d_ready[0]) got++;
            end
            chk("d_grants", got, 5);
            @(posedge clk); #1; d_req[0] = 0;
         end
      join
      chk("sb0_drained", sb0.size(), 0);

      // Reset during WAIT on the RD_LAT=3 arbiter: abort with no ready.
      @(posedge clk); #1;
      e.port = 0; e.we = '0; e.addr = 32'h90; e.wdata = '0; e.data = 32'h5555_AAAA; e.rdy = -1;
      push(1, e);
      i_req[1] = 1; i_addr[1] = 32'h90;
      repeat (2) @(posedge clk);
      #1; rst[1] = 1; i_req[1] = 0; sb1.delete();
      @(negedge clk);
      chk("abort_busy", 32'(busy[1]), 0);
      chk("abort_mem_en", 32'(mem_en[1]), 0);
      chk("abort_ready", 32'({i_ready[1], d_ready[1]}), 0);
      @(posedge clk); #1; rst[1] = 0;
      repeat (6) @(posedge clk);
      do_txn(1, 0, 4'h0, 32'h90, 0, 32'h5555_AAAA, 5);

      // Fetch address toggled while in flight must not affect the access.
      fork
         do_txn(1, 0, 4'h0, 32'hA0, 0, 32'h0BAD_F00D, 5);
         begin
            repeat (3) @(posedge clk);
            #1 i_addr[1] = 32'hC0;
            @(posedge clk); #1 i_addr[1] = 32'hA4;
         end
      join

      // Byte store into byte 1 only, then load back with RD_LAT=3.
      do_txn(1, 1, 4'b0010, 32'h80, 32'hAABB_CCDD, 0, 2);
      do_txn(1, 1, 4'h0, 32'h80, 0, 32'h1122_CC44, 5);

      repeat (4) @(posedge clk);
      chk("sb1_drained", sb1.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
